// File: rtl/shift_pkg.sv
// shift_pkg: shared defaults and fill-state naming for the tapped shift register.
package shift_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 3;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} fill_state_e;
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one word register with load enable and synchronous clear.
module shift_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (rst || clr) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/shift_n_multi_read.sv
// shift_n_multi_read: DEPTH-stage tapped shift register with eviction, fill tracking and flush.
// Defining SHIFT_RD_PORT_EN adds a registered random-read port (rd_idx/rd_data).
module shift_n_multi_read
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write_en,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       data_in,
`ifdef SHIFT_RD_PORT_EN
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [WIDTH-1:0]       rd_data,
`endif
  output logic [WIDTH-1:0]       data_out,
  output logic                   out_valid,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [CNT_W-1:0]       fill_count,
  output logic                   full
);
  // slot 0 is data_in, slot k+1 is the output of stage k
  logic [WIDTH*(DEPTH+1)-1:0] w_chain;
  logic [WIDTH-1:0]           r_data_out;
  logic                       r_out_valid;
  logic [CNT_W-1:0]           r_fill;
  logic                       r_full;
  assign w_chain[WIDTH-1:0] = data_in;
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    shift_stage #(.WIDTH(WIDTH)) u_stage (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .en  (write_en),
      .d   (w_chain[k*WIDTH +: WIDTH]),
      .q   (w_chain[(k+1)*WIDTH +: WIDTH])
    );
  end
  always_ff @(posedge clk)
    if (rst || flush) begin
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_fill      <= '0;
      r_full      <= 1'b0;
    end else if (write_en) begin
      r_data_out  <= w_chain[DEPTH*WIDTH +: WIDTH];
      r_out_valid <= r_full;
      r_fill      <= r_full ? r_fill : r_fill + CNT_W'(1);
      r_full      <= r_full || (r_fill == CNT_W'(DEPTH-1));
    end else begin
      r_out_valid <= 1'b0;
    end
  assign data_out   = r_data_out;
  assign out_valid  = r_out_valid;
  assign fill_count = r_fill;
  assign full       = r_full;
  assign taps       = w_chain[WIDTH*(DEPTH+1)-1:WIDTH];
`ifdef SHIFT_RD_PORT_EN
  logic [WIDTH-1:0] w_rd;
  logic [WIDTH-1:0] r_rd_data;
  // out-of-range indices fall through to zero
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < DEPTH; i++)
      if (int'(rd_idx) == i) w_rd = w_chain[(i+1)*WIDTH +: WIDTH];
  end
  always_ff @(posedge clk)
    if (rst || flush) r_rd_data <= '0;
    else r_rd_data <= w_rd;
  assign rd_data = r_rd_data;
`endif
endmodule

// File: tb/tb_shift_n_multi_read.sv
// tb_shift_n_multi_read: directed checks of fill, eviction, gaps, flush, reset and optional read port.
module tb_shift_n_multi_read;
  localparam int W = 32;
  localparam int D = 3;
  localparam int CW = $clog2(D+1);
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          write_en = 1'b0;
  logic          flush = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic [W-1:0]  data_out;
  logic          out_valid;
  logic [W*D-1:0] taps;
  logic [CW-1:0] fill_count;
  logic          full;
  int            errors = 0;
  int            checks = 0;
`ifdef SHIFT_RD_PORT_EN
  logic [$clog2(D)-1:0] rd_idx = '0;
  logic [W-1:0]         rd_data;
`endif

  shift_n_multi_read #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .write_en   (write_en),
    .flush      (flush),
    .data_in    (data_in),
`ifdef SHIFT_RD_PORT_EN
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
`endif
    .data_out   (data_out),
    .out_valid  (out_valid),
    .taps       (taps),
    .fill_count (fill_count),
    .full       (full)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic we, input logic fl, input logic [W-1:0] d);
    rst = r; write_en = we; flush = fl; data_in = d;
    @(posedge clk); #1;
    rst = 1'b0; write_en = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    checks++; if (taps !== '0) begin errors++; $display("FAIL reset_taps got=%h exp=0", taps); end
    checks++; if ({data_out, out_valid, fill_count, full} !== '0) begin errors++;
      $display("FAIL reset_ctl got dout=%h v=%b cnt=%0d full=%b exp all 0", data_out, out_valid, fill_count, full); end
  endtask

  task automatic test_fill();
    logic [W-1:0] v [3] = '{32'hA, 32'hB, 32'hC};
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, v[i]);
      checks++; if (fill_count !== CW'(i+1)) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, fill_count, i+1); end
      checks++; if (full !== (i == 2)) begin errors++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, i == 2); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_valid[%0d] got=%b exp=0", i, out_valid); end
      checks++; if (taps[W-1:0] !== v[i]) begin errors++; $display("FAIL fill_tap0[%0d] got=%h exp=%h", i, taps[W-1:0], v[i]); end
    end
    checks++; if (taps !== {32'hA, 32'hB, 32'hC}) begin errors++; $display("FAIL fill_taps got=%h exp=%h", taps, {32'hA, 32'hB, 32'hC}); end
  endtask

  task automatic test_eviction();
    step(0, 1, 0, 32'hD);
    checks++; if (data_out !== 32'hA || out_valid !== 1'b1) begin errors++; $display("FAIL evict_d got dout=%h v=%b exp dout=a v=1", data_out, out_valid); end
    step(0, 1, 0, 32'hE);
    checks++; if (data_out !== 32'hB || out_valid !== 1'b1) begin errors++; $display("FAIL evict_e got dout=%h v=%b exp dout=b v=1", data_out, out_valid); end
    checks++; if (taps !== {32'hC, 32'hD, 32'hE}) begin errors++; $display("FAIL evict_taps got=%h exp=%h", taps, {32'hC, 32'hD, 32'hE}); end
    checks++; if (fill_count !== CW'(3) || full !== 1'b1) begin errors++; $display("FAIL evict_cnt got cnt=%0d full=%b exp 3/1", fill_count, full); end
  endtask

  task automatic test_gaps();
    logic [W*D-1:0] held;
    step(1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 0, W'(i));
      checks++; if (out_valid !== (i == 4)) begin errors++; $display("FAIL gap_wr_valid[%0d] got=%b exp=%b", i, out_valid, i == 4); end
      held = taps;
      step(0, 0, 0, 32'hFF);
      checks++; if (taps !== held) begin errors++; $display("FAIL gap_hold[%0d] got=%h exp=%h", i, taps, held); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_idle_valid[%0d] got=%b exp=0", i, out_valid); end
    end
    checks++; if (data_out !== 32'h1) begin errors++; $display("FAIL gap_dout_hold got=%h exp=1", data_out); end
    checks++; if (taps !== {32'h2, 32'h3, 32'h4}) begin errors++; $display("FAIL gap_taps got=%h exp=%h", taps, {32'h2, 32'h3, 32'h4}); end
  endtask

  task automatic test_flush();
    step(0, 1, 1, 32'hF);
    checks++; if (taps !== '0) begin errors++; $display("FAIL flush_taps got=%h exp=0", taps); end
    checks++; if ({data_out, out_valid, fill_count, full} !== '0) begin errors++;
      $display("FAIL flush_ctl got dout=%h v=%b cnt=%0d full=%b exp all 0", data_out, out_valid, fill_count, full); end
    step(0, 1, 0, 32'h7);
    checks++; if (fill_count !== CW'(1) || taps !== {64'h0, 32'h7}) begin errors++; $display("FAIL flush_next got cnt=%0d taps=%h exp cnt=1 taps=7", fill_count, taps); end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 0);
    step(0, 1, 0, 32'hA);
    step(0, 1, 0, 32'hB);
    step(1, 1, 0, 32'h55);
    checks++; if (taps !== '0) begin errors++; $display("FAIL rstmid_taps got=%h exp=0", taps); end
    checks++; if ({data_out, out_valid, fill_count, full} !== '0) begin errors++;
      $display("FAIL rstmid_ctl got dout=%h v=%b cnt=%0d full=%b exp all 0", data_out, out_valid, fill_count, full); end
    step(1, 0, 1, 32'h66);
    checks++; if (taps !== '0 || fill_count !== '0) begin errors++; $display("FAIL rstmid_flush got taps=%h cnt=%0d exp 0/0", taps, fill_count); end
    step(0, 1, 0, 32'h9);
    checks++; if (fill_count !== CW'(1) || taps !== {64'h0, 32'h9} || out_valid !== 1'b0) begin errors++;
      $display("FAIL rstmid_next got cnt=%0d taps=%h v=%b exp cnt=1 taps=9 v=0", fill_count, taps, out_valid); end
  endtask

`ifdef SHIFT_RD_PORT_EN
  task automatic test_rd_port();
    step(1, 0, 0, 0);
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL rd_reset got=%h exp=0", rd_data); end
    step(0, 1, 0, 32'hA);
    step(0, 1, 0, 32'hB);
    step(0, 1, 0, 32'hC);
    rd_idx = 1;
    step(0, 0, 0, 0);
    checks++; if (rd_data !== 32'hB) begin errors++; $display("FAIL rd_idx1 got=%h exp=b", rd_data); end
    step(0, 1, 0, 32'hD);
    checks++; if (rd_data !== 32'hB) begin errors++; $display("FAIL rd_preshift got=%h exp=b", rd_data); end
    rd_idx = 0;
    step(0, 0, 0, 0);
    checks++; if (rd_data !== 32'hD) begin errors++; $display("FAIL rd_idx0 got=%h exp=d", rd_data); end
    rd_idx = 3;
    step(0, 0, 0, 0);
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL rd_oob got=%h exp=0", rd_data); end
    rd_idx = 2;
    step(0, 0, 1, 0);
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL rd_flush got=%h exp=0", rd_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_eviction();
    test_gaps();
    test_flush();
    test_reset_mid();
`ifdef SHIFT_RD_PORT_EN
    test_rd_port();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
